// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register slice sequencer: slice mode encoding,
// fill selection and sequencer state.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_SHIFTR = 2'b01,
    MODE_SHIFTL = 2'b10,
    MODE_HOLD   = 2'b11
  } tMode141;

  typedef enum logic [1:0] {
    FILL_ZERO  = 2'd0,
    FILL_ONES  = 2'd1,
    FILL_ARITH = 2'd2,
    FILL_ROT   = 2'd3
  } tFill;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tShiftSeqState;

  function automatic tMode141 shift_mode(input logic dir);
    return dir ? MODE_SHIFTR : MODE_SHIFTL;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Remaining-shift down-counter for shift_seq; flags are decoded from the register.
// Latency: load/decrement visible the cycle after the edge. No backpressure.
// Decrement saturates at zero.
module shift_seq_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] din,
  output logic             isOne,
  output logic             isZero
);

  logic [CNT_W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec && !isZero) begin
      q <= q - CNT_W'(1);
    end
  end

  assign isOne  = (q == CNT_W'(1));
  assign isZero = (q == '0);

endmodule

// File: rtl/shift_seq.sv
// Sequencer driving mode/serial-fill of a 4-bit universal shift-register chain.
// Latency: start edge to done cycle = loadFirst + count + 1. start ignored unless IDLE.
// Optional abort input when SHIFT_SEQ_ABORT_EN is defined.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       fill,
  input  logic [CNT_W-1:0] count,
  input  logic             loadFirst,
  input  logic             bit0Q,
  input  logic             bitNQ,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             op2,
  output logic             op1,
  output logic             shft0in,
  output logic             shftNin,
  output logic             busy,
  output logic             done
);

  tShiftSeqState state, nxt;
  tMode141       mode;
  logic          dirQ;
  tFill          fillQ;
  logic          accept;
  logic          cntOne, cntZero;
  logic          abortHit;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abortHit = abort;
`else
  assign abortHit = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && start;

  shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .dec    (state == ST_SHIFT),
    .din    (count),
    .isOne  (cntOne),
    .isZero (cntZero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      dirQ  <= 1'b0;
      fillQ <= FILL_ZERO;
    end else begin
      state <= nxt;
      if (accept) begin
        dirQ  <= dir;
        fillQ <= tFill'(fill);
      end
    end
  end

  always_comb begin
    nxt     = state;
    mode    = MODE_HOLD;
    shft0in = 1'b0;
    shftNin = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (loadFirst)          nxt = ST_LOAD;
          else if (count != '0)   nxt = ST_SHIFT;
          else                    nxt = ST_DONE;
        end
      end
      ST_LOAD: begin
        mode = MODE_LOAD;
        nxt  = cntZero ? ST_DONE : ST_SHIFT;
        if (abortHit) nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        mode = shift_mode(dirQ);
        // Leave on the last shift so exactly 'count' SHIFT cycles are presented.
        nxt  = (cntOne || cntZero) ? ST_DONE : ST_SHIFT;
        if (abortHit) nxt = ST_IDLE;
        if (!dirQ) begin
          case (fillQ)
            FILL_ZERO:  shft0in = 1'b0;
            FILL_ONES:  shft0in = 1'b1;
            FILL_ARITH: shft0in = bit0Q;
            FILL_ROT:   shft0in = bitNQ;
            default:    shft0in = 1'b0;
          endcase
        end else begin
          case (fillQ)
            FILL_ONES:  shftNin = 1'b1;
            FILL_ROT:   shftNin = bit0Q;
            default:    shftNin = 1'b0;
          endcase
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign {op2, op1} = mode;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares whenever the DUT is busy.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic reset, start, dir, loadFirst;
  logic [1:0] fill;
  logic [CNT_W-1:0] count;
  logic bit0Q, bitNQ;
  logic op2, op1, shft0in, shftNin, busy, done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic abort;
`endif

  // Behavioural 8-bit chain (two slices) driven by the DUT's mode/fill outputs.
  logic [7:0] chain = 8'h00;
  logic [7:0] par_in;
  logic fb_force, b0_f, bN_f;

  assign bit0Q = fb_force ? b0_f : chain[0];
  assign bitNQ = fb_force ? bN_f : chain[7];

  always #5 clk = ~clk;

  shift_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .fill      (fill),
    .count     (count),
    .loadFirst (loadFirst),
    .bit0Q     (bit0Q),
    .bitNQ     (bitNQ),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .op2       (op2),
    .op1       (op1),
    .shft0in   (shft0in),
    .shftNin   (shftNin),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) begin
    case ({op2, op1})
      2'b00:   chain <= par_in;
      2'b01:   chain <= {shftNin, chain[7:1]};
      2'b10:   chain <= {chain[6:0], shft0in};
      default: chain <= chain;
    endcase
  end

  typedef struct packed {
    logic [1:0] mode;
    logic       s0;
    logic       sN;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t expq[$];
  exp_t mon_act, mon_exp;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (!reset && (busy || done)) begin
      mon_act = {op2, op1, shft0in, shftNin, busy, done};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL mon_extra_cycle actual={mode,s0,sN,busy,done}=%b expected=<none>", mon_act);
      end else begin
        mon_exp = expq.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL mon_cycle actual={mode,s0,sN,busy,done}=%b expected=%b", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_shift(input logic d, input logic [1:0] f, input int n,
                            input logic lf, input logic b0, input logic bN);
    exp_t e;
    if (lf) expq.push_back(6'b00_0_0_1_0);
    for (int i = 0; i < n; i++) begin
      e.mode = d ? 2'b01 : 2'b10;
      e.s0 = 1'b0; e.sN = 1'b0; e.busy = 1'b1; e.done = 1'b0;
      if (!d) begin
        case (f)
          2'd0:    e.s0 = 1'b0;
          2'd1:    e.s0 = 1'b1;
          2'd2:    e.s0 = b0;
          default: e.s0 = bN;
        endcase
      end else begin
        case (f)
          2'd1:    e.sN = 1'b1;
          2'd3:    e.sN = b0;
          default: e.sN = 1'b0;
        endcase
      end
      expq.push_back(e);
    end
    expq.push_back(6'b11_0_0_1_1);
  endtask

  // Caller is at negedge+1 with the DUT idle; inputs are scrambled after acceptance.
  task automatic issue(input logic d, input logic [1:0] f, input int n,
                       input logic lf, output int lat);
    lat = -1;
    dir = d; fill = f; count = CNT_W'(n); loadFirst = lf; start = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        start = 1'b0; dir = ~d; fill = ~f; count = ~count; loadFirst = ~lf;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    @(negedge clk); #1;
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("queue_drained", expq.size(), 32'd0);
    expq.delete();
  endtask

  task automatic run(input logic d, input logic [1:0] f, input int n,
                     input logic lf, input logic b0, input logic bN);
    int lat;
    fb_force = 1'b1; b0_f = b0; bN_f = bN;
    push_shift(d, f, n, lf, b0, bN);
    issue(d, f, n, lf, lat);
    check("latency", lat, lf + n + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   done_seen;
    logic [7:0] r;
    reset = 1'b1; start = 1'b0; dir = 1'b0; fill = 2'd0; count = '0; loadFirst = 1'b0;
    fb_force = 1'b1; b0_f = 1'b0; bN_f = 1'b0; par_in = 8'h00;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk); #1;
    check("rst_mode", {30'd0, op2, op1}, 32'h3);
    check("rst_shft0in", {31'd0, shft0in}, 32'd0);
    check("rst_shftNin", {31'd0, shftNin}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    run(1'b1, 2'd0, 3, 1'b1, 1'b0, 1'b0);   // LOAD, 3x SHIFTR zero fill
    run(1'b0, 2'd2, 4, 1'b0, 1'b1, 1'b0);   // arith left, sign=1
    run(1'b0, 2'd2, 4, 1'b0, 1'b0, 1'b1);   // arith left, sign=0
    run(1'b0, 2'd1, 2, 1'b0, 1'b0, 1'b0);
    run(1'b1, 2'd1, 2, 1'b0, 1'b0, 1'b0);
    run(1'b1, 2'd2, 3, 1'b0, 1'b1, 1'b1);   // arith right fills 0
    run(1'b0, 2'd3, 2, 1'b0, 1'b0, 1'b1);
    run(1'b1, 2'd3, 2, 1'b1, 1'b1, 1'b0);
    run(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);   // count 0: straight to DONE

    par_in = 8'h08;
    run(1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0);   // LOAD then DONE
    check("chain_loaded", {24'd0, chain}, 32'h08);

    // 63-place right rotate through live chain feedback.
    fb_force = 1'b0;
    r = 8'h08;
    for (int i = 0; i < 63; i++) begin
      expq.push_back({2'b01, 1'b0, r[0], 1'b1, 1'b0});
      r = {r[0], r[7:1]};
    end
    expq.push_back(6'b11_0_0_1_1);
    issue(1'b1, 2'd3, 63, 1'b0, lat);
    check("rot63_latency", lat, 32'd64);
    check("rot63_chain", {24'd0, chain}, 32'h10);
    fb_force = 1'b1;

    // start pulsed during SHIFT and in the done cycle must be ignored.
    b0_f = 1'b0; bN_f = 1'b0;
    push_shift(1'b0, 2'd1, 5, 1'b0, 1'b0, 1'b0);
    dir = 1'b0; fill = 2'd1; count = CNT_W'(5); loadFirst = 1'b0; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; count = CNT_W'(1); loadFirst = 1'b1; dir = 1'b1; end
      if (k == 4) start = 1'b0;
      if (lat > 0 && k == lat + 1) begin
        start = 1'b0;
        check("ign_idle_busy", {31'd0, busy}, 32'd0);
        check("ign_idle_mode", {30'd0, op2, op1}, 32'h3);
        break;
      end
      if (done && lat < 0) begin
        lat = k; start = 1'b1; count = CNT_W'(2);
      end
    end
    start = 1'b0;
    check("ign_latency", lat, 32'd6);
    check("ign_queue", expq.size(), 32'd0);
    expq.delete();
    repeat (4) @(negedge clk); #1;

    // Reset after 5 of 20 shifts: silent abort, then immediate restart.
    for (int i = 0; i < 5; i++) expq.push_back(6'b10_0_0_1_0);
    dir = 1'b0; fill = 2'd0; count = CNT_W'(20); loadFirst = 1'b0; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_mode", {30'd0, op2, op1}, 32'h3);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_queue", expq.size(), 32'd0);
    expq.delete();
    reset = 1'b0;
    run(1'b0, 2'd1, 2, 1'b0, 1'b0, 1'b0);

`ifdef SHIFT_SEQ_ABORT_EN
    for (int i = 0; i < 2; i++) expq.push_back(6'b10_0_0_1_0);
    dir = 1'b0; fill = 2'd0; count = CNT_W'(10); loadFirst = 1'b0; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 2) abort = 1'b1;
      if (k == 3) abort = 1'b0;
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mode", {30'd0, op2, op1}, 32'h3);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    check("abort_queue", expq.size(), 32'd0);
    expq.delete();
`else
    done_seen = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
